// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver, with a first-word-fall-through read port, fill level, overrun and irq.
// Optional idle-timeout interrupt is compiled in with `define UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
    parameter int DEPTH          = 8,
    parameter int ADDR_W         = 3,
    parameter int IRQ_LEVEL      = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              rx_en,
    input  logic [7:0]        rx_data,
    input  logic              rx_status,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              clr_overrun,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    output logic              irq
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] IRQ_C   = (ADDR_W+1)'(IRQ_LEVEL);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              stat_p1;
    logic              stat_p2;
    logic              push_req;
    logic              pop;
    logic              do_push;
    logic              do_pop;
    logic              drop;
    logic              timeout_flag;

    assign push_req = stat_p1 & ~stat_p2 & rx_en;
    assign pop      = rd_en & rd_valid;
    // A pop in the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign do_push  = push_req & ~flush & (~full | pop);
    assign do_pop   = pop & ~flush;
    assign drop     = push_req & ~flush & full & ~pop;

    assign rd_valid = (count != '0);
    assign full     = (count == DEPTH_C);
    assign rd_data  = mem[rd_ptr];
    assign irq      = (count >= IRQ_C) | overrun | timeout_flag;

    // stage p1/p2: rx_status edge detect; rx_data is taken one edge after the pulse is seen
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            stat_p1 <= 1'b0;
            stat_p2 <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            stat_p1 <= rx_status;
            stat_p2 <= stat_p1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (do_push && !do_pop)
                    count <= count + 1'b1;
                else if (!do_push && do_pop)
                    count <= count - 1'b1;
            end
            if (drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push)
            mem[wr_ptr] <= rx_data;
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] idle_cnt;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else if (push_req || pop || flush || count == '0) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else if (count < IRQ_C) begin
            // Below the level threshold a trickle of bytes still raises irq after the idle period.
            if (idle_cnt == TO_LAST)
                timeout_flag <= 1'b1;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_flag = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table-driven fill vectors, hand-written corner sequences, and a byte scoreboard queue.
// A second instance (IRQ_LEVEL=4, TIMEOUT_CYCLES=16) covers the level threshold and the optional timeout irq.
module tb_uart_rx_fifo;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       rd_en;
    logic       flush;
    logic       clr_overrun;
    logic [7:0] rd_data, rd_data2;
    logic       rd_valid, rd_valid2;
    logic       full, full2;
    logic [3:0] count, count2;
    logic       overrun, overrun2;
    logic       irq, irq2;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       en;
        logic       acc;
        int         exp_count;
        logic       exp_full;
        logic       exp_ovr;
    } vec_t;
    vec_t vecs[10];

    always #5 sysclk = ~sysclk;

    uart_rx_fifo #(.DEPTH(8), .ADDR_W(3), .IRQ_LEVEL(1), .TIMEOUT_CYCLES(1024)) dut (
        .sysclk(sysclk), .reset(reset), .rx_en(rx_en), .rx_data(rx_data),
        .rx_status(rx_status), .rd_en(rd_en), .flush(flush), .clr_overrun(clr_overrun),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .count(count),
        .overrun(overrun), .irq(irq)
    );

    uart_rx_fifo #(.DEPTH(8), .ADDR_W(3), .IRQ_LEVEL(4), .TIMEOUT_CYCLES(16)) dut2 (
        .sysclk(sysclk), .reset(reset), .rx_en(rx_en), .rx_data(rx_data),
        .rx_status(rx_status), .rd_en(rd_en), .flush(flush), .clr_overrun(clr_overrun),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .full(full2), .count(count2),
        .overrun(overrun2), .irq(irq2)
    );

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data   = b;
        rx_status = 1'b1;
        tick;
        rx_status = 1'b0;
        tick;
    endtask

    task automatic pop_check(input string name);
        check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
        if (exp_q.size() == 0)
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        else
            check(name, {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h01, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        vecs[1] = '{8'h02, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        vecs[2] = '{8'h03, 1'b1, 1'b1, 3, 1'b0, 1'b0};
        vecs[3] = '{8'h04, 1'b1, 1'b1, 4, 1'b0, 1'b0};
        vecs[4] = '{8'hEE, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[5] = '{8'h05, 1'b1, 1'b1, 5, 1'b0, 1'b0};
        vecs[6] = '{8'h06, 1'b1, 1'b1, 6, 1'b0, 1'b0};
        vecs[7] = '{8'h07, 1'b1, 1'b1, 7, 1'b0, 1'b0};
        vecs[8] = '{8'h08, 1'b1, 1'b1, 8, 1'b1, 1'b0};
        vecs[9] = '{8'h09, 1'b1, 1'b0, 8, 1'b1, 1'b1};

        reset = 1'b1; rx_en = 1'b1; rx_data = 8'h00; rx_status = 1'b0;
        rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        tick; tick;
        reset = 1'b1;
        tick;

        // single byte latency
        rx_data = 8'hA5; rx_status = 1'b1;
        tick;
        check("lat_count_n", {28'd0, count}, 32'd0);
        rx_status = 1'b0;
        tick;
        exp_q.push_back(8'hA5);
        check("lat_count", {28'd0, count}, 32'd1);
        check("lat_irq", {31'd0, irq}, 32'd1);
        pop_check("lat_data");
        check("lat_pop_count", {28'd0, count}, 32'd0);
        check("lat_pop_valid", {31'd0, rd_valid}, 32'd0);
        check("lat_pop_irq", {31'd0, irq}, 32'd0);

        // table-driven fill up to and past full
        for (int i = 0; i < 10; i++) begin
            rx_en = vecs[i].en;
            push_byte(vecs[i].data);
            rx_en = 1'b1;
            if (vecs[i].acc) exp_q.push_back(vecs[i].data);
            check($sformatf("vec%0d_count", i), {28'd0, count}, vecs[i].exp_count);
            check($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vecs[i].exp_full});
            check($sformatf("vec%0d_ovr", i), {31'd0, overrun}, {31'd0, vecs[i].exp_ovr});
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, 32'd1);
        end
        for (int i = 0; i < 8; i++) pop_check($sformatf("drain%0d", i));
        check("drain_valid", {31'd0, rd_valid}, 32'd0);
        check("drain_ovr_sticky", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1; tick; clr_overrun = 1'b0;
        check("clr_ovr", {31'd0, overrun}, 32'd0);

        // push and pop in the same edge while full
        for (int i = 0; i < 8; i++) begin
            push_byte(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        check("refill_full", {31'd0, full}, 32'd1);
        rx_data = 8'h55; rx_status = 1'b1;
        tick;
        rx_status = 1'b0;
        check("pp_head", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        exp_q.push_back(8'h55);
        check("pp_count", {28'd0, count}, 32'd8);
        check("pp_ovr", {31'd0, overrun}, 32'd0);
        check("pp_head_adv", {24'd0, rd_data}, {24'd0, exp_q[0]});

        // overrun set beats clear in the same edge
        rx_data = 8'h66; rx_status = 1'b1;
        tick;
        rx_status = 1'b0; clr_overrun = 1'b1;
        tick;
        clr_overrun = 1'b0;
        check("set_wins_ovr", {31'd0, overrun}, 32'd1);
        check("set_wins_count", {28'd0, count}, 32'd8);
        clr_overrun = 1'b1; tick; clr_overrun = 1'b0;
        check("set_wins_clr", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 8; i++) pop_check($sformatf("pp_drain%0d", i));
        check("pp_drain_valid", {31'd0, rd_valid}, 32'd0);

        // wide rx_status pulse and disabled capture
        rx_data = 8'h3C; rx_status = 1'b1;
        tick; tick; tick;
        rx_status = 1'b0;
        tick; tick;
        exp_q.push_back(8'h3C);
        check("wide_count", {28'd0, count}, 32'd1);
        rx_en = 1'b0;
        push_byte(8'h77);
        rx_en = 1'b1;
        check("rxen0_count", {28'd0, count}, 32'd1);
        pop_check("wide_data");

        // flush keeps overrun
        for (int i = 0; i < 8; i++) begin
            push_byte(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        push_byte(8'h99);
        for (int i = 0; i < 3; i++) pop_check($sformatf("fl_pop%0d", i));
        check("fl_pre_count", {28'd0, count}, 32'd5);
        check("fl_pre_ovr", {31'd0, overrun}, 32'd1);
        flush = 1'b1; tick; flush = 1'b0;
        exp_q.delete();
        check("fl_count", {28'd0, count}, 32'd0);
        check("fl_valid", {31'd0, rd_valid}, 32'd0);
        check("fl_full", {31'd0, full}, 32'd0);
        check("fl_ovr", {31'd0, overrun}, 32'd1);
        rd_en = 1'b1; tick; rd_en = 1'b0;
        check("empty_rd_count", {28'd0, count}, 32'd0);
        clr_overrun = 1'b1; tick; clr_overrun = 1'b0;

        // streaming across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            push_byte(8'h80 + 8'(i));
            exp_q.push_back(8'h80 + 8'(i));
            if (exp_q.size() >= 4) pop_check($sformatf("wrap_pop%0d", i));
            check($sformatf("wrap_count%0d", i), {28'd0, count}, exp_q.size());
            check($sformatf("wrap_le8_%0d", i), {31'd0, (count <= 4'd8)}, 32'd1);
        end
        while (exp_q.size() > 0) pop_check("wrap_drain");
        check("wrap_empty", {31'd0, rd_valid}, 32'd0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) push_byte(8'h40 + 8'(i));
        check("mid_pre_count", {28'd0, count}, 32'd3);
        reset = 1'b0;
        #1;
        check("mid_count", {28'd0, count}, 32'd0);
        check("mid_valid", {31'd0, rd_valid}, 32'd0);
        check("mid_full", {31'd0, full}, 32'd0);
        check("mid_ovr", {31'd0, overrun}, 32'd0);
        check("mid_irq", {31'd0, irq}, 32'd0);
        tick;
        reset = 1'b1;
        tick;

        // level threshold and idle timeout on the IRQ_LEVEL=4 instance
        push_byte(8'hC3);
        exp_q.push_back(8'hC3);
        check("to_count2", {28'd0, count2}, 32'd1);
        check("to_irq2_early", {31'd0, irq2}, 32'd0);
        repeat (8) tick;
        check("to_irq2_mid", {31'd0, irq2}, 32'd0);
        repeat (20) tick;
`ifdef UART_RX_FIFO_TIMEOUT_EN
        check("to_irq2_late", {31'd0, irq2}, 32'd1);
`else
        check("to_irq2_late", {31'd0, irq2}, 32'd0);
`endif
        pop_check("to_data");
        check("to_irq2_pop", {31'd0, irq2}, 32'd0);
        check("to_irq_pop", {31'd0, irq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
